// File: rtl/cycle_sequencer_pkg.sv
// Shared encodings and sizing for the instruction cycle sequencer.
package cycle_sequencer_pkg;

  localparam int SEQ_STEPS   = 4;
  localparam int SEQ_MCYCLES = 8;

  typedef enum logic [1:0] {
    SEQ_BOOT = 2'b00,
    SEQ_RUN  = 2'b01,
    SEQ_HALT = 2'b10
  } seq_state_e;

endpackage

// File: rtl/cycle_sequencer_onehot_ring.sv
// One-hot rotating ring, resets to bit0 and advances left when enabled.
module cycle_sequencer_onehot_ring #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] ring
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ring <= WIDTH'(1);
    end else if (en) begin
      ring <= {ring[WIDTH-2:0], ring[WIDTH-1]};
    end
  end

endmodule

// File: rtl/cycle_sequencer.sv
// T-state / M-cycle timing generator with boot-fetch, run and halt sequencing.
//
// state | meaning
// BOOT  | standalone opcode-fetch M-cycle (after reset or wake)
// RUN   | executing instruction M-cycles, count is one-hot
// HALT  | step ring free-runs, count zero, waiting for wake at M-cycle end
module cycle_sequencer
  import cycle_sequencer_pkg::*;
#(
  parameter int STEPS   = SEQ_STEPS,
  parameter int MCYCLES = SEQ_MCYCLES
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic               i_Stall,
  input  logic               i_IR_Fetch,
  input  logic               i_Halt_Req,
  input  logic               i_Wake,
  output logic [STEPS-1:0]   o_Cycle_Step,
  output logic [MCYCLES-1:0] o_Cycle_Count,
  output logic               o_Run,
  output logic               o_Fetch_Cycle,
  output logic               o_IR_Load,
  output logic               o_M_Cycle_End,
  output logic               o_Halted,
  output logic               o_Seq_Fault
);

  seq_state_e         state, state_nxt;
  logic [MCYCLES-1:0] count, count_nxt;
  logic               fault, fault_nxt;
  logic               ir_load;
  logic               m_end;

  cycle_sequencer_onehot_ring #(.WIDTH(STEPS)) u_step_ring (
    .clk   (i_Clk),
    .rst_n (i_Rst_n),
    .en    (~i_Stall),
    .ring  (o_Cycle_Step)
  );

  assign m_end = o_Cycle_Step[STEPS-1] & ~i_Stall;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state <= SEQ_BOOT;
      count <= '0;
      fault <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      fault <= fault_nxt;
    end
  end

  // Every transition is gated by the M-cycle end so mid-cycle inputs are ignored.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    fault_nxt = fault;
    ir_load   = 1'b0;
    if (m_end) begin
      case (state)
        SEQ_BOOT: begin
          state_nxt = SEQ_RUN;
          count_nxt = MCYCLES'(1);
          ir_load   = 1'b1;
        end
        SEQ_RUN: begin
          if (i_IR_Fetch && i_Halt_Req) begin
            state_nxt = SEQ_HALT;
            count_nxt = '0;
          end else if (i_IR_Fetch) begin
            count_nxt = MCYCLES'(1);
            ir_load   = 1'b1;
          end else if (count[MCYCLES-1]) begin
            fault_nxt = 1'b1;
          end else begin
            count_nxt = count << 1;
          end
        end
        SEQ_HALT: begin
          count_nxt = '0;
          if (i_Wake) state_nxt = SEQ_BOOT;
        end
        default: begin
          state_nxt = SEQ_BOOT;
          count_nxt = '0;
        end
      endcase
    end
  end

  assign o_Cycle_Count = count;
  assign o_Run         = (state == SEQ_RUN);
  assign o_Fetch_Cycle = (state == SEQ_BOOT);
  assign o_Halted      = (state == SEQ_HALT);
  assign o_Seq_Fault   = fault;
  assign o_IR_Load     = ir_load;
  assign o_M_Cycle_End = m_end;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer: boot, run, stall, halt/wake, fault, async reset.
module tb_cycle_sequencer;

  logic       i_Clk;
  logic       i_Rst_n;
  logic       i_Stall;
  logic       i_IR_Fetch;
  logic       i_Halt_Req;
  logic       i_Wake;
  logic [3:0] o_Cycle_Step;
  logic [7:0] o_Cycle_Count;
  logic       o_Run;
  logic       o_Fetch_Cycle;
  logic       o_IR_Load;
  logic       o_M_Cycle_End;
  logic       o_Halted;
  logic       o_Seq_Fault;

  int checks = 0;
  int errors = 0;
  int loads  = 0;

  cycle_sequencer dut (
    .i_Clk         (i_Clk),
    .i_Rst_n       (i_Rst_n),
    .i_Stall       (i_Stall),
    .i_IR_Fetch    (i_IR_Fetch),
    .i_Halt_Req    (i_Halt_Req),
    .i_Wake        (i_Wake),
    .o_Cycle_Step  (o_Cycle_Step),
    .o_Cycle_Count (o_Cycle_Count),
    .o_Run         (o_Run),
    .o_Fetch_Cycle (o_Fetch_Cycle),
    .o_IR_Load     (o_IR_Load),
    .o_M_Cycle_End (o_M_Cycle_End),
    .o_Halted      (o_Halted),
    .o_Seq_Fault   (o_Seq_Fault)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 2 units after the edge.
  task automatic next;
    @(posedge i_Clk);
    #2;
  endtask

  task automatic next_n(input int n);
    for (int k = 0; k < n; k++) next();
  endtask

  initial begin
    i_Rst_n    = 1'b0;
    i_Stall    = 1'b0;
    i_IR_Fetch = 1'b0;
    i_Halt_Req = 1'b0;
    i_Wake     = 1'b0;
    next_n(2);
    chk("rst_step", 32'(o_Cycle_Step), 32'h1);
    chk("rst_count", 32'(o_Cycle_Count), 32'h0);
    chk("rst_fetch", 32'(o_Fetch_Cycle), 32'h1);
    i_Rst_n = 1'b1;
    #1;

    // 1: boot fetch M-cycle
    for (int s = 0; s < 4; s++) begin
      chk("boot_fetch", 32'(o_Fetch_Cycle), 32'h1);
      chk("boot_step", 32'(o_Cycle_Step), 32'(1 << s));
      chk("boot_irload", 32'(o_IR_Load), (s == 3) ? 32'h1 : 32'h0);
      chk("boot_mend", 32'(o_M_Cycle_End), (s == 3) ? 32'h1 : 32'h0);
      next();
    end
    chk("boot_run", 32'(o_Run), 32'h1);
    chk("boot_count", 32'(o_Cycle_Count), 32'h01);
    chk("boot_step_wrap", 32'(o_Cycle_Step), 32'h1);
    chk("boot_fetch_off", 32'(o_Fetch_Cycle), 32'h0);

    // 2: four M-cycle instruction, fetch only in the last one
    for (int m = 0; m < 4; m++) begin
      i_IR_Fetch = (m == 3);
      #1;
      for (int s = 0; s < 4; s++) begin
        chk("run_count", 32'(o_Cycle_Count), 32'(1 << m));
        chk("run_step", 32'(o_Cycle_Step), 32'(1 << s));
        chk("run_irload", 32'(o_IR_Load), (s == 3 && m == 3) ? 32'h1 : 32'h0);
        if (o_IR_Load) loads++;
        next();
      end
    end
    i_IR_Fetch = 1'b0;
    #1;
    chk("run_loads", 32'(loads), 32'h1);
    chk("run_restart", 32'(o_Cycle_Count), 32'h01);

    // 3: stall mid M-cycle, then stall on the last step
    next_n(6);
    chk("stall_pre_step", 32'(o_Cycle_Step), 32'h4);
    chk("stall_pre_count", 32'(o_Cycle_Count), 32'h02);
    i_Stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      next();
      chk("stall_step", 32'(o_Cycle_Step), 32'h4);
      chk("stall_count", 32'(o_Cycle_Count), 32'h02);
      chk("stall_mend", 32'(o_M_Cycle_End), 32'h0);
    end
    i_Stall = 1'b0;
    next();
    chk("resume_step", 32'(o_Cycle_Step), 32'h8);
    chk("resume_mend", 32'(o_M_Cycle_End), 32'h1);
    i_Stall = 1'b1;
    i_IR_Fetch = 1'b1;
    #1;
    chk("stall_end_mend", 32'(o_M_Cycle_End), 32'h0);
    chk("stall_end_irload", 32'(o_IR_Load), 32'h0);
    next();
    chk("stall_end_step", 32'(o_Cycle_Step), 32'h8);
    chk("stall_end_count", 32'(o_Cycle_Count), 32'h02);
    i_Stall = 1'b0;
    i_IR_Fetch = 1'b0;
    next();
    chk("resume_wrap_step", 32'(o_Cycle_Step), 32'h1);
    chk("resume_wrap_count", 32'(o_Cycle_Count), 32'h04);

    // 4: halt, ignored wake pulse, real wake
    i_Halt_Req = 1'b1;
    next();
    i_Halt_Req = 1'b0;
    next_n(2);
    i_IR_Fetch = 1'b1;
    i_Halt_Req = 1'b1;
    #1;
    chk("halt_irload", 32'(o_IR_Load), 32'h0);
    next();
    i_IR_Fetch = 1'b0;
    i_Halt_Req = 1'b0;
    chk("halt_flag", 32'(o_Halted), 32'h1);
    chk("halt_count", 32'(o_Cycle_Count), 32'h00);
    chk("halt_run", 32'(o_Run), 32'h0);
    next();
    chk("halt_step", 32'(o_Cycle_Step), 32'h2);
    i_Wake = 1'b1;
    next();
    i_Wake = 1'b0;
    next_n(2);
    chk("halt_wake_ignored", 32'(o_Halted), 32'h1);
    chk("halt_ring_runs", 32'(o_Cycle_Step), 32'h1);
    i_Wake = 1'b1;
    next_n(3);
    chk("wake_mend", 32'(o_M_Cycle_End), 32'h1);
    next();
    i_Wake = 1'b0;
    chk("wake_fetch", 32'(o_Fetch_Cycle), 32'h1);
    chk("wake_halted", 32'(o_Halted), 32'h0);
    chk("wake_count", 32'(o_Cycle_Count), 32'h00);
    next_n(3);
    chk("wake_irload", 32'(o_IR_Load), 32'h1);
    next();
    chk("wake_run", 32'(o_Run), 32'h1);
    chk("wake_run_count", 32'(o_Cycle_Count), 32'h01);

    // 5: runaway instruction saturates and faults
    for (int m = 0; m < 9; m++) begin
      chk("sat_count", 32'(o_Cycle_Count), (m < 7) ? 32'(1 << m) : 32'h80);
      chk("sat_fault", 32'(o_Seq_Fault), (m == 8) ? 32'h1 : 32'h0);
      next_n(4);
    end
    chk("sat_hold", 32'(o_Cycle_Count), 32'h80);
    i_IR_Fetch = 1'b1;
    next_n(3);
    chk("sat_irload", 32'(o_IR_Load), 32'h1);
    next();
    i_IR_Fetch = 1'b0;
    chk("fault_sticky", 32'(o_Seq_Fault), 32'h1);
    chk("fault_restart", 32'(o_Cycle_Count), 32'h01);

    // 6: asynchronous reset mid M-cycle
    next_n(10);
    chk("pre_rst_step", 32'(o_Cycle_Step), 32'h4);
    chk("pre_rst_count", 32'(o_Cycle_Count), 32'h04);
    i_Rst_n = 1'b0;
    #1;
    chk("arst_step", 32'(o_Cycle_Step), 32'h1);
    chk("arst_count", 32'(o_Cycle_Count), 32'h00);
    chk("arst_run", 32'(o_Run), 32'h0);
    chk("arst_fetch", 32'(o_Fetch_Cycle), 32'h1);
    chk("arst_halted", 32'(o_Halted), 32'h0);
    chk("arst_fault", 32'(o_Seq_Fault), 32'h0);
    chk("arst_irload", 32'(o_IR_Load), 32'h0);
    chk("arst_mend", 32'(o_M_Cycle_End), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
